// File: rtl/l2_icache_resp.sv
// L2-side responder for L1 icache refills: direct-mapped L2 lookup, memory refill on miss.
// Optional: define L2_IC_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module l2_icache_resp #(
    parameter int ADDR_W = 28,
    parameter int IDX_W  = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        irq,
    input  logic [ADDR_W-1:0]           l2_addr,
    input  logic                        dc_busy,
    output logic                        ic_en,
    output logic                        l2_rdy,
    output logic                        mem_wr_ic_en,
    output logic [127:0]                data_wd_l2,
    output logic                        complete,
    output logic [IDX_W-1:0]            l2_index,
    output logic                        l2_re,
    input  logic [ADDR_W-2-IDX_W:0]     l2_tag_rd,
    input  logic [511:0]                l2_data_rd,
    output logic                        l2_we,
    output logic [ADDR_W-2-IDX_W:0]     l2_tag_wd,
    output logic [511:0]                l2_data_wd,
    output logic                        mem_req,
    output logic [ADDR_W-3:0]           mem_addr,
    input  logic                        mem_rdy,
    input  logic [511:0]                mem_rd
`ifdef L2_IC_STATS_EN
    ,
    output logic [31:0]                 hit_cnt,
    output logic [31:0]                 miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_COMPARE, S_MEM, S_RESP, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [127:0]        r_data;
    logic                w_hit;
    logic                w_accept;
    logic [TAG_W-1:0]    w_tag;

    function automatic logic [127:0] pick_blk(input logic [511:0] line, input logic [1:0] sel);
        return line[{sel, 7'd0} +: 128];
    endfunction

    assign w_tag    = r_addr[ADDR_W-1:ADDR_W-TAG_W];
    assign w_hit    = l2_tag_rd[TAG_W] && (l2_tag_rd[TAG_W-1:0] == w_tag);
    assign w_accept = irq && !dc_busy && !rst;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (irq && !dc_busy) w_next = S_LOOKUP;
            S_LOOKUP:  w_next = S_COMPARE;
            S_COMPARE: w_next = w_hit ? S_RESP : S_MEM;
            S_MEM:     if (mem_rdy) w_next = S_RESP;
            S_RESP:    w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Pulses are gated by rst so a reset landing mid-transaction never writes L2.
    always_comb begin
        ic_en        = 1'b1;
        l2_re        = 1'b0;
        l2_rdy       = 1'b0;
        mem_wr_ic_en = 1'b0;
        complete     = 1'b0;
        l2_we        = 1'b0;
        mem_req      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ic_en = !dc_busy;
                l2_re = w_accept;
            end
            S_COMPARE: begin
                l2_rdy  = w_hit && !rst;
                mem_req = !w_hit;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                l2_we        = mem_rdy && !rst;
                mem_wr_ic_en = mem_rdy && !rst;
            end
            S_RESP:  complete = !rst;
            default: ;
        endcase
        if (l2_rdy)            data_wd_l2 = pick_blk(l2_data_rd, r_addr[1:0]);
        else if (mem_wr_ic_en) data_wd_l2 = pick_blk(mem_rd, r_addr[1:0]);
        else                   data_wd_l2 = r_data;
    end

    // Index follows the live address only on the accept cycle; afterwards the latched one.
    assign l2_index   = l2_re ? l2_addr[IDX_W+1:2] : r_addr[IDX_W+1:2];
    assign l2_tag_wd  = {l2_we, w_tag};
    assign l2_data_wd = mem_rd;
    assign mem_addr   = r_addr[ADDR_W-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_data <= '0;
        end else begin
            if (w_accept && r_state == S_IDLE) r_addr <= l2_addr;
            if (l2_rdy || mem_wr_ic_en)        r_data <= data_wd_l2;
        end
    end

`ifdef L2_IC_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_COMPARE) begin
            if (w_hit) begin
                if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_l2_icache_resp.sv
// Scoreboard bench for l2_icache_resp: hit/miss refills, dc_busy arbitration, reset mid-refill.
module tb_l2_icache_resp;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         irq = 1'b0;
    logic [27:0]  l2_addr = '0;
    logic         dc_busy = 1'b0;
    logic [17:0]  l2_tag_rd = '0;
    logic [511:0] l2_data_rd = '0;
    logic         mem_rdy = 1'b0;
    logic [511:0] mem_rd = '0;

    logic         ic_en, l2_rdy, mem_wr_ic_en, complete, l2_re, l2_we, mem_req;
    logic [127:0] data_wd_l2;
    logic [8:0]   l2_index;
    logic [17:0]  l2_tag_wd;
    logic [511:0] l2_data_wd;
    logic [25:0]  mem_addr;
`ifdef L2_IC_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    l2_icache_resp dut (
        .clk(clk), .rst(rst), .irq(irq), .l2_addr(l2_addr), .dc_busy(dc_busy),
        .ic_en(ic_en), .l2_rdy(l2_rdy), .mem_wr_ic_en(mem_wr_ic_en),
        .data_wd_l2(data_wd_l2), .complete(complete), .l2_index(l2_index),
        .l2_re(l2_re), .l2_tag_rd(l2_tag_rd), .l2_data_rd(l2_data_rd),
        .l2_we(l2_we), .l2_tag_wd(l2_tag_wd), .l2_data_wd(l2_data_wd),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_rd(mem_rd)
`ifdef L2_IC_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         mem;
        logic [127:0] blk;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_hits = 0;
    int   exp_miss = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every block delivered to L1 must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && (l2_rdy || mem_wr_ic_en)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {l2_rdy, mem_wr_ic_en}, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_path", {l2_rdy, mem_wr_ic_en}, {~e.mem, e.mem});
                chk("sb_block", data_wd_l2, e.blk);
            end
        end
    end

    task automatic run_txn(input logic [27:0] addr, input logic hit, input logic inval,
                           input int busy_cyc, input logic busy_in_mem);
        logic [127:0] w[4];
        logic [511:0] line;
        for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom, $urandom, $urandom};
        line = {w[3], w[2], w[1], w[0]};
        @(posedge clk); #1;
        l2_addr    = addr;
        irq        = 1'b1;
        l2_tag_rd  = hit ? {1'b1, addr[27:11]}
                   : (inval ? {1'b0, addr[27:11]} : {1'b1, addr[27:11] ^ 17'h1});
        l2_data_rd = hit ? line : ~line;
        mem_rd     = '0;
        if (busy_cyc > 0) begin
            dc_busy = 1'b1;
            for (int i = 0; i < busy_cyc; i++) begin
                @(negedge clk);
                chk("busy_ic_en", ic_en, 0);
                chk("busy_no_re", l2_re, 0);
                @(posedge clk); #1;
            end
            dc_busy = 1'b0;
        end
        sb_q.push_back('{mem: ~hit, blk: w[addr[1:0]]});
        if (hit) exp_hits++;
        else     exp_miss++;
        @(negedge clk);
        chk("acc_re", l2_re, 1);
        chk("acc_index", l2_index, addr[10:2]);
        chk("acc_ic_en", ic_en, 1);
        @(posedge clk); #1;
        l2_addr = ~addr;
        @(negedge clk);
        chk("lookup_quiet", {l2_re, l2_rdy, mem_req, complete}, 0);
        @(negedge clk);
        if (hit) begin
            chk("hit_rdy", {l2_rdy, mem_req}, 2'b10);
        end else begin
            chk("miss_req", {l2_rdy, mem_req}, 2'b01);
            chk("miss_maddr", mem_addr, addr[27:2]);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (busy_in_mem && i == 1) dc_busy = 1'b1;
                @(negedge clk);
                chk("mem_hold", {mem_req, l2_we, mem_wr_ic_en}, 3'b100);
                chk("mem_maddr", mem_addr, addr[27:2]);
                chk("mem_ic_en", ic_en, 1);
            end
            @(posedge clk); #1;
            mem_rdy = 1'b1;
            mem_rd  = line;
            @(negedge clk);
            chk("fill_we", {l2_we, mem_wr_ic_en, l2_rdy}, 3'b110);
            chk("fill_index", l2_index, addr[10:2]);
            chk("fill_tag", l2_tag_wd, {1'b1, addr[27:11]});
            chk("fill_data", l2_data_wd, line);
            @(posedge clk); #1;
            mem_rdy = 1'b0;
        end
        @(negedge clk);
        chk("resp_complete", {complete, l2_rdy, mem_wr_ic_en, l2_we}, 4'b1000);
        chk("resp_hold", data_wd_l2, w[addr[1:0]]);
        @(posedge clk); #1;
        irq     = 1'b0;
        dc_busy = 1'b0;
        @(negedge clk);
        chk("done_quiet", {complete, l2_re, mem_req, l2_rdy}, 0);
        chk("done_hold", data_wd_l2, w[addr[1:0]]);
        chk("done_ic_en", ic_en, 1);
        @(negedge clk);
        chk("idle_ic_en", ic_en, 1);
        chk("idle_quiet", {l2_re, complete, mem_req}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        dc_busy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_ic_en", ic_en, 0);
        @(posedge clk); #1;
        dc_busy = 1'b0;
        @(negedge clk);
        chk("rst_ic_en", ic_en, 1);
        chk("rst_ctrl", {l2_re, l2_rdy, mem_wr_ic_en, complete, l2_we, mem_req}, 0);
        chk("rst_data", data_wd_l2, 0);
        chk("rst_addr", {mem_addr, l2_index, l2_tag_wd}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(28'h0000403, 1'b1, 1'b0, 0, 1'b0);
        run_txn(28'h0000403, 1'b0, 1'b1, 0, 1'b0);
        run_txn(28'h1234566, 1'b0, 1'b0, 4, 1'b1);
        run_txn(28'hFEDCBA9, 1'b1, 1'b0, 0, 1'b0);
        run_txn(28'h0000400, 1'b1, 1'b0, 2, 1'b0);

        // Reset lands in MEM together with mem_rdy.
        @(posedge clk); #1;
        l2_addr   = 28'h0ABCDE7;
        l2_tag_rd = 18'h0;
        irq       = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstm_req", mem_req, 1);
        @(negedge clk);
        chk("rstm_in_mem", {mem_req, l2_we}, 2'b10);
        @(posedge clk); #1;
        rst     = 1'b1;
        mem_rdy = 1'b1;
        mem_rd  = {16{32'hDEAD_BEEF}};
        @(negedge clk);
        chk("rstm_no_we", {l2_we, mem_wr_ic_en}, 0);
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        irq     = 1'b0;
        @(negedge clk);
        chk("rstm_req_drop", {mem_req, l2_we}, 0);
        chk("rstm_idle_ic_en", ic_en, 1);
        chk("rstm_data_clr", data_wd_l2, 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        mem_rd   = '0;
        exp_hits = 0;
        exp_miss = 0;

        run_txn(28'h7654322, 1'b1, 1'b0, 0, 1'b0);
        run_txn(28'h0C00801, 1'b0, 1'b1, 0, 1'b0);
        run_txn(28'h0C00801, 1'b1, 1'b0, 0, 1'b0);
        run_txn(28'h3FFFFFF, 1'b0, 1'b0, 0, 1'b0);
        run_txn(28'h0000002, 1'b1, 1'b0, 1, 1'b0);

`ifdef L2_IC_STATS_EN
        chk("stat_hits", hit_cnt, exp_hits);
        chk("stat_miss", miss_cnt, exp_miss);
        force dut.r_hit_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.r_hit_cnt;
        run_txn(28'h0000403, 1'b1, 1'b0, 0, 1'b0);
        chk("stat_hit_sat", hit_cnt, 32'hFFFF_FFFF);
`endif

        chk("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
